// File: rtl/chip_prog_receiver_if.sv
// Serial programming link between the FPGA (master) and the chip-side receiver (slave).
// Carries the raw sclk/sdin pair and the receiver's status and gain outputs.
interface chip_prog_receiver_if;
   logic       i_sclk;
   logic       i_sdin;
   logic [2:0] o_gainA1;
   logic [1:0] o_gainA2;
   logic       o_ready;
   logic       o_busy;
   logic       o_frame_err;

   modport master (
      output i_sclk, i_sdin,
      input  o_gainA1, o_gainA2, o_ready, o_busy, o_frame_err
   );

   modport slave (
      input  i_sclk, i_sdin,
      output o_gainA1, o_gainA2, o_ready, o_busy, o_frame_err
   );
endinterface

// File: rtl/chip_prog_receiver.sv
// Chip-side programming receiver: oversamples sclk/sdin, shifts in a 5-bit MSB-first
// frame, latches the A1/A2 gain codes once and aborts stalled frames on timeout.
module chip_prog_receiver #(
   parameter int NBITS      = 5,
   parameter int TIMEOUT    = 64,
   parameter int SYNC_DEPTH = 2   // must be >= 2
) (
   input  logic                 i_mainclk,
   input  logic                 i_reset,
   chip_prog_receiver_if.slave  prog
);

   localparam int            TO_W     = $clog2(TIMEOUT) + 1;
   localparam logic [2:0]    LAST_BIT = 3'(NBITS - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

   state_t                state_q, state_d;
   logic [SYNC_DEPTH-1:0] sclk_sync, sdin_sync;
   logic                  d_sclk;
   logic                  s_sclk, s_sdin, rise, fall;
   logic                  shift_en, abort;
   logic [NBITS-1:0]      shift_q;
   logic [2:0]            bit_cnt_q;
   logic [TO_W-1:0]       to_cnt_q;
   logic [2:0]            gain_a1_q;
   logic [1:0]            gain_a2_q;
   logic                  ready_q, busy_q, frame_err_q;

   // NOTE: synchronizers and the edge history reset to the sclk idle level (1) so that
   // leaving reset never manufactures a fall edge; plain state registers reset to 0.
   always_ff @(posedge i_mainclk) begin
      if (i_reset) begin
         sclk_sync <= '1;
         sdin_sync <= '1;
         d_sclk    <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_DEPTH-2:0], prog.i_sclk};
         sdin_sync <= {sdin_sync[SYNC_DEPTH-2:0], prog.i_sdin};
         d_sclk    <= s_sclk;
      end
   end

   assign s_sclk = sclk_sync[SYNC_DEPTH-1];
   assign s_sdin = sdin_sync[SYNC_DEPTH-1];
   assign rise   = s_sclk & ~d_sclk;
   assign fall   = ~s_sclk & d_sclk;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE:  if (fall) state_d = SHIFT;
         SHIFT: begin
            // An edge in the terminal-count cycle wins over the abort.
            if (rise) begin
               shift_en = 1'b1;
               if (bit_cnt_q == LAST_BIT) state_d = LATCH;
            end else if (!fall && to_cnt_q == TO_LAST) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         LATCH:   state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge i_mainclk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         gain_a1_q   <= '0;
         gain_a2_q   <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_q      <= (state_d == SHIFT);
         frame_err_q <= abort;

         if (state_q == IDLE && fall) begin
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
         end

         if (state_q == SHIFT) begin
            if (rise || fall)        to_cnt_q <= '0;
            else if (to_cnt_q != TO_MAX) to_cnt_q <= to_cnt_q + 1'b1;

            if (shift_en) begin
               shift_q   <= {shift_q[NBITS-2:0], s_sdin};
               bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (abort) bit_cnt_q <= '0;
         end

         if (state_q == LATCH) begin
            gain_a1_q <= shift_q[4:2];
            gain_a2_q <= shift_q[1:0];
            ready_q   <= 1'b1;
         end
      end
   end

   assign prog.o_gainA1    = gain_a1_q;
   assign prog.o_gainA2    = gain_a2_q;
   assign prog.o_ready     = ready_q;
   assign prog.o_busy      = busy_q;
   assign prog.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_chip_prog_receiver.sv
// Bench for chip_prog_receiver: directed link scenarios plus randomized frames,
// aborts and mid-frame resets, checked against a frame-level reference model.
module tb_chip_prog_receiver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   err_cycles = 0;

   chip_prog_receiver_if bus ();

   chip_prog_receiver dut (
      .i_mainclk (clk),
      .i_reset   (rst),
      .prog      (bus)
   );

   always #5 clk = ~clk;

   // Counts every cycle o_frame_err is high; an abort must add exactly one.
   always @(negedge clk) if (bus.o_frame_err === 1'b1) err_cycles++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.i_sclk = 1'b1;
      bus.i_sdin = 1'b0;
      step(2);
      rst = 1'b0;
   endtask

   // FPGA-like bits: data changes with each sclk fall, sampled on the rise.
   task automatic send_bits(input logic [4:0] bits, input int nb, input int half);
      for (int i = 0; i < nb; i++) begin
         bus.i_sclk = 1'b0;
         bus.i_sdin = bits[4-i];
         step(half);
         bus.i_sclk = 1'b1;
         step(half);
      end
   endtask

   // Full frame with exact latency check; model decodes the bit list arithmetically.
   task automatic send_frame(input logic [4:0] bits, input int half, input string tag);
      int exp_a1, exp_a2;
      exp_a1 = (bits[4] ? 4 : 0) + (bits[3] ? 2 : 0) + (bits[2] ? 1 : 0);
      exp_a2 = (bits[1] ? 2 : 0) + (bits[0] ? 1 : 0);
      for (int i = 0; i < 5; i++) begin
         bus.i_sclk = 1'b0;
         bus.i_sdin = bits[4-i];
         step(half);
         if (i == 0) check({tag, ".busy_shift"}, bus.o_busy, 1);
         bus.i_sclk = 1'b1;
         if (i < 4) step(half);
         else begin
            step(3);
            check({tag, ".ready_early"}, bus.o_ready, 0);
            step(1);
            check({tag, ".ready"}, bus.o_ready, 1);
            check({tag, ".gainA1"}, bus.o_gainA1, exp_a1);
            check({tag, ".gainA2"}, bus.o_gainA2, exp_a2);
            check({tag, ".busy_after"}, bus.o_busy, 0);
            step(half - 4);
         end
      end
   endtask

   task automatic abort_frame(input logic [4:0] bits, input int nb, input int half,
                              input string tag);
      int e0;
      e0 = err_cycles;
      send_bits(bits, nb, half);
      step(100);
      check({tag, ".err_pulse"}, err_cycles - e0, 1);
      check({tag, ".ready"}, bus.o_ready, 0);
      check({tag, ".busy"}, bus.o_busy, 0);
   endtask

   task automatic done_toggles(input int n, input string tag);
      logic [2:0] a1;
      logic [1:0] a2;
      int         e0;
      a1 = bus.o_gainA1;
      a2 = bus.o_gainA2;
      e0 = err_cycles;
      for (int i = 0; i < n; i++) begin
         bus.i_sclk = ~bus.i_sclk;
         bus.i_sdin = 1'($urandom);
         step(4);
      end
      bus.i_sclk = 1'b1;
      step(8);
      check({tag, ".hold_a1"}, bus.o_gainA1, a1);
      check({tag, ".hold_a2"}, bus.o_gainA2, a2);
      check({tag, ".hold_ready"}, bus.o_ready, 1);
      check({tag, ".hold_busy"}, bus.o_busy, 0);
      check({tag, ".hold_err"}, err_cycles - e0, 0);
   endtask

   task automatic mid_reset(input logic [4:0] bits, input int nb, input int half,
                            input string tag);
      send_bits(bits, nb, half);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check({tag, ".rst_a1"}, bus.o_gainA1, 0);
      check({tag, ".rst_a2"}, bus.o_gainA2, 0);
      check({tag, ".rst_ready"}, bus.o_ready, 0);
      check({tag, ".rst_busy"}, bus.o_busy, 0);
      check({tag, ".rst_err"}, bus.o_frame_err, 0);
   endtask

   initial begin
      int e0, busy_seen, half, nb, kind;
      logic [4:0] bits;

      do_reset();
      check("reset.a1", bus.o_gainA1, 0);
      check("reset.a2", bus.o_gainA2, 0);
      check("reset.ready", bus.o_ready, 0);
      check("reset.busy", bus.o_busy, 0);
      check("reset.err", bus.o_frame_err, 0);

      send_frame(5'b11001, 16, "t1");

      do_reset();
      send_frame(5'b00011, 16, "t2");
      done_toggles(10, "t2");

      do_reset();
      abort_frame(5'b10100, 3, 16, "t3");
      send_frame(5'b10110, 16, "t3b");

      do_reset();
      mid_reset(5'b11000, 2, 16, "t4");
      send_frame(5'b01110, 16, "t4b");

      do_reset();
      e0 = err_cycles;
      send_frame(5'b11111, 4, "t5");
      check("t5.no_err", err_cycles - e0, 0);

      do_reset();
      e0 = err_cycles;
      busy_seen = 0;
      for (int i = 0; i < 200; i++) begin
         bus.i_sdin = ~bus.i_sdin;
         step(1);
         if (bus.o_busy) busy_seen++;
      end
      check("t6.busy_seen", busy_seen, 0);
      check("t6.no_err", err_cycles - e0, 0);
      check("t6.ready", bus.o_ready, 0);
      send_frame(5'b01011, 8, "t6b");

      // Long but sub-timeout gaps between edges must not abort.
      do_reset();
      e0 = err_cycles;
      send_frame(5'b10011, 28, "slow");
      check("slow.no_err", err_cycles - e0, 0);

      for (int it = 0; it < 16; it++) begin
         bits = 5'($urandom);
         half = int'($urandom_range(4, 24));
         nb   = int'($urandom_range(1, 4));
         kind = int'($urandom_range(0, 2));
         do_reset();
         e0 = err_cycles;
         if (kind == 1) abort_frame(5'($urandom), nb, half, "rnd_abort");
         else if (kind == 2) mid_reset(5'($urandom), nb, half, "rnd_rst");
         send_frame(bits, half, "rnd");
         if (kind != 1) check("rnd.no_err", err_cycles - e0, 0);
         done_toggles(int'($urandom_range(2, 10)), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
